// File: rtl/wb_regfile_pkg.sv
// Shared definitions for the writeback / architectural-state stage.
// Holds the write-selector bit positions, the sequencing FSM states and
// the default reset PC used by wb_regfile and regfile32.
package wb_regfile_pkg;

    // Bit positions inside ex_wsel
    localparam int WSEL_PC = 2;   // redirect PC to ex_pc_out
    localparam int WSEL_WR = 1;   // perform a register write
    localparam int WSEL_F  = 0;   // target file: 1 = FPR, 0 = GPR

    localparam logic [4:0]  REG_ZERO         = 5'd0;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch/execute sequencing states
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_regfile_regfile32.sv
// regfile32: 32 x 32-bit register file with one write port and two
// registered read ports. A read that hits the same-cycle write returns the
// write data. With HARDZERO set, index 0 ignores writes and reads as zero.
// All entries and read registers clear on synchronous active-low reset.
module regfile32
    import wb_regfile_pkg::*;
#(
    parameter bit HARDZERO = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o
);

    logic [31:0] mem_q [32];
    logic        wr_ok;
    logic [31:0] rdata_a_d, rdata_a_q;
    logic [31:0] rdata_b_d, rdata_b_q;

    assign wr_ok = we_i && !(HARDZERO && (waddr_i == REG_ZERO));

    // Read value for one port, including write-through of the current write
    function automatic logic [31:0] read_port(input logic [4:0] addr);
        logic [31:0] val;
        if (HARDZERO && (addr == REG_ZERO)) begin
            val = 32'h0;
        end else if (wr_ok && (waddr_i == addr)) begin
            val = wdata_i;
        end else begin
            val = mem_q[addr];
        end
        return val;
    endfunction

    // Combinational read selection for both ports
    always_comb begin
        rdata_a_d = read_port(raddr_a_i);
        rdata_b_d = read_port(raddr_b_i);
    end

    // Storage array: cleared on reset, otherwise one write per cycle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (wr_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read ports (one-cycle latency)
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdata_a_q <= 32'h0;
            rdata_b_q <= 32'h0;
        end else begin
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback and architectural-state stage.
// Commits execute results to the GPR and FPR files, owns the architectural
// PC, paces fetch against execute completion and serves decode's two
// operand read ports.
// Optional feature: define WB_RETIRE_COUNT_EN to add the 64-bit instret
// output counting retired pulses.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] PC_STEP  = 32'h4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ex_done,
    input  logic        ex_stall,
    input  logic [2:0]  ex_wsel,
    input  logic        ex_wfrommem,
    input  logic [31:0] ex_data,
    input  logic [31:0] mem_rdata,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_pc_out,
    input  logic [4:0]  rs_no,
    input  logic [4:0]  rt_no,
    input  logic        fmode1,
    input  logic        fmode2,
    output logic [31:0] rs_val,
    output logic [31:0] rt_val,
    output logic [31:0] pc,
    output logic        fetch_en,
    output logic        retired
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [63:0] instret
`endif
);

    logic [31:0] wdata;
    logic        gpr_we, fpr_we;
    logic [31:0] gpr_a, gpr_b, fpr_a, fpr_b;
    logic        fmode1_q, fmode2_q;

    wb_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fetch_q, fetch_d;
    logic        retired_q, retired_d;

    // Writes are independent of ex_done; the file is picked by the F bit
    assign wdata  = ex_wfrommem ? mem_rdata : ex_data;
    assign gpr_we = ex_wsel[WSEL_WR] && !ex_wsel[WSEL_F];
    assign fpr_we = ex_wsel[WSEL_WR] &&  ex_wsel[WSEL_F];

    regfile32 #(.HARDZERO(1'b1)) u_gpr (
        .clk       (clk),
        .rstn      (rstn),
        .we_i      (gpr_we),
        .waddr_i   (ex_rd),
        .wdata_i   (wdata),
        .raddr_a_i (rs_no),
        .raddr_b_i (rt_no),
        .rdata_a_o (gpr_a),
        .rdata_b_o (gpr_b)
    );

    regfile32 #(.HARDZERO(1'b0)) u_fpr (
        .clk       (clk),
        .rstn      (rstn),
        .we_i      (fpr_we),
        .waddr_i   (ex_rd),
        .wdata_i   (wdata),
        .raddr_a_i (rs_no),
        .raddr_b_i (rt_no),
        .rdata_a_o (fpr_a),
        .rdata_b_o (fpr_b)
    );

    // File selects are delayed to line up with the registered read data
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fmode1_q <= 1'b0;
            fmode2_q <= 1'b0;
        end else begin
            fmode1_q <= fmode1;
            fmode2_q <= fmode2;
        end
    end

    assign rs_val = fmode1_q ? fpr_a : gpr_a;
    assign rt_val = fmode2_q ? fpr_b : gpr_b;

    // Sequencing state, PC and status pulse registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            fetch_q   <= 1'b0;
            retired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            fetch_q   <= fetch_d;
            retired_q <= retired_d;
        end
    end

    // Next state: completion in WAIT updates the PC; ex_done elsewhere is ignored
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fetch_d   = 1'b0;
        retired_d = 1'b0;
        case (state_q)
            BOOT: begin
                fetch_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (ex_done) begin
                    state_d = ISSUE;
                    if (ex_stall) begin
                        // squashed wrong-path instruction: redirect only
                        pc_d = ex_pc_out;
                    end else if (ex_wsel[WSEL_PC]) begin
                        pc_d      = ex_pc_out;
                        retired_d = 1'b1;
                    end else begin
                        pc_d      = pc_q + PC_STEP;
                        retired_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                fetch_d = 1'b1;
                state_d = WAIT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign pc       = pc_q;
    assign fetch_en = fetch_q;
    assign retired  = retired_q;

`ifdef WB_RETIRE_COUNT_EN
    logic [63:0] instret_q;

    // Retired-instruction counter, bumped on the same edge retired rises
    always_ff @(posedge clk) begin
        if (!rstn) begin
            instret_q <= 64'h0;
        end else if (retired_d) begin
            instret_q <= instret_q + 64'h1;
        end
    end

    assign instret = instret_q;
`endif

endmodule
